// File: rtl/aw_writeback_packer.sv
// aw_writeback_packer
// Collects per-column activation writeback lanes into private FIFOs and packs
// PACK same-column elements into one wide beat for the write DMA. Columns are
// served round-robin. Elements that arrive at a full FIFO are dropped, and each
// drop is recorded in sticky status flags.
module aw_writeback_packer #(
   parameter int ARRAY_WIDTH = 16,
   parameter int QSIZE       = 8,
   parameter int PACK        = 4,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic [QSIZE-1:0]               aw_cb_data [ARRAY_WIDTH],
   input  logic [ARRAY_WIDTH-1:0]         aw_cb_valid,
   input  logic                           i_flush,
   input  logic                           i_clear_status,
   output logic [PACK*QSIZE-1:0]          o_data,
   output logic [PACK-1:0]                o_keep,
   output logic [$clog2(ARRAY_WIDTH)-1:0] o_col,
   output logic                           o_valid,
   input  logic                           o_ready,
   output logic                           o_flush_done,
   output logic                           o_overflow,
   output logic [ARRAY_WIDTH-1:0]         o_ovf_mask,
   output logic                           o_idle
);

   localparam int COL_W = $clog2(ARRAY_WIDTH);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] PACK_CNT = CNT_W'(PACK);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(ARRAY_WIDTH - 1);

   // Column FIFO storage and bookkeeping
   logic [QSIZE-1:0]       mem_q   [ARRAY_WIDTH][FIFO_DEPTH];
   logic [PTR_W-1:0]       wrPtr_q [ARRAY_WIDTH];
   logic [PTR_W-1:0]       wrPtr_d [ARRAY_WIDTH];
   logic [PTR_W-1:0]       rdPtr_q [ARRAY_WIDTH];
   logic [PTR_W-1:0]       rdPtr_d [ARRAY_WIDTH];
   logic [CNT_W-1:0]       count_q [ARRAY_WIDTH];
   logic [CNT_W-1:0]       count_d [ARRAY_WIDTH];

   // Arbitration and control state
   logic [COL_W-1:0]       rr_q, rr_d;
   logic                   flushPending_q, flushPending_d;
   logic                   flushDone_q, flushDone_d;
   logic [ARRAY_WIDTH-1:0] ovfMask_q, ovfMask_d;

   // Output beat register
   logic                   oValid_q, oValid_d;
   logic [PACK*QSIZE-1:0]  oData_q, oData_d;
   logic [PACK-1:0]        oKeep_q, oKeep_d;
   logic [COL_W-1:0]       oCol_q, oCol_d;

   // Combinational helpers
   logic [ARRAY_WIDTH-1:0] eligible;
   logic                   allEmpty;
   logic                   hiFound, loFound, winFound;
   logic [COL_W-1:0]       hiCol, loCol, winCol;
   logic [CNT_W-1:0]       winCount, popNum;
   logic                   load;
   logic [PACK*QSIZE-1:0]  beatData;
   logic [PACK-1:0]        beatKeep;
   logic [ARRAY_WIDTH-1:0] popSel, pushOk, drop;
   logic                   flushEff, flushFinish;

   // A column may be served once it holds a full beat, or any data during a flush
   always_comb begin
      allEmpty = 1'b1;
      eligible = '0;
      for (int c = 0; c < ARRAY_WIDTH; c++) begin
         eligible[c] = (count_q[c] >= PACK_CNT) || (flushPending_q && (count_q[c] != '0));
         if (count_q[c] != '0) begin
            allEmpty = 1'b0;
         end
      end
   end

   // Round-robin pick: lowest eligible column at or above rr, else lowest overall
   always_comb begin
      hiFound = 1'b0;
      hiCol   = '0;
      loFound = 1'b0;
      loCol   = '0;
      for (int c = ARRAY_WIDTH - 1; c >= 0; c--) begin
         if (eligible[c]) begin
            loFound = 1'b1;
            loCol   = COL_W'(c);
            if (COL_W'(c) >= rr_q) begin
               hiFound = 1'b1;
               hiCol   = COL_W'(c);
            end
         end
      end
      winFound = loFound;
      winCol   = hiFound ? hiCol : loCol;
   end

   // Assemble the candidate beat from the winner's oldest entries, zero-padding unused lanes
   always_comb begin
      winCount = count_q[winCol];
      popNum   = (winCount >= PACK_CNT) ? PACK_CNT : winCount;
      load     = winFound && (!oValid_q || o_ready);
      beatData = '0;
      beatKeep = '0;
      for (int k = 0; k < PACK; k++) begin
         if (CNT_W'(k) < popNum) begin
            beatData[k*QSIZE +: QSIZE] = mem_q[winCol][rdPtr_q[winCol] + PTR_W'(k)];
            beatKeep[k] = 1'b1;
         end
      end
   end

   // Per-column push/pop accounting; a pop in the same cycle makes room for a push into a full FIFO
   always_comb begin
      popSel = '0;
      pushOk = '0;
      drop   = '0;
      for (int c = 0; c < ARRAY_WIDTH; c++) begin
         popSel[c]  = load && (winCol == COL_W'(c));
         pushOk[c]  = aw_cb_valid[c] && ((count_q[c] != FULL_CNT) || popSel[c]);
         drop[c]    = aw_cb_valid[c] && (count_q[c] == FULL_CNT) && !popSel[c];
         wrPtr_d[c] = wrPtr_q[c] + PTR_W'(pushOk[c]);
         rdPtr_d[c] = rdPtr_q[c] + (popSel[c] ? PTR_W'(popNum) : '0);
         count_d[c] = count_q[c] + CNT_W'(pushOk[c]) - (popSel[c] ? popNum : '0);
      end
   end

   // Output register, arbitration pointer, flush tracking and sticky drop flags
   always_comb begin
      oValid_d = oValid_q;
      oData_d  = oData_q;
      oKeep_d  = oKeep_q;
      oCol_d   = oCol_q;
      rr_d     = rr_q;
      if (load) begin
         oValid_d = 1'b1;
         oData_d  = beatData;
         oKeep_d  = beatKeep;
         oCol_d   = winCol;
         rr_d     = (winCol == LAST_COL) ? '0 : winCol + 1'b1;
      end else if (o_ready) begin
         oValid_d = 1'b0;
      end

      flushEff       = flushPending_q || i_flush;
      flushFinish    = flushEff && allEmpty && (!oValid_q || o_ready);
      flushPending_d = flushEff && !flushFinish;
      flushDone_d    = flushFinish;

      ovfMask_d = (i_clear_status ? '0 : ovfMask_q) | drop;
   end

   // State register; reset discards all buffered data and any held beat
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < ARRAY_WIDTH; c++) begin
            wrPtr_q[c] <= '0;
            rdPtr_q[c] <= '0;
            count_q[c] <= '0;
         end
         rr_q           <= '0;
         flushPending_q <= 1'b0;
         flushDone_q    <= 1'b0;
         ovfMask_q      <= '0;
         oValid_q       <= 1'b0;
         oData_q        <= '0;
         oKeep_q        <= '0;
         oCol_q         <= '0;
      end else begin
         for (int c = 0; c < ARRAY_WIDTH; c++) begin
            wrPtr_q[c] <= wrPtr_d[c];
            rdPtr_q[c] <= rdPtr_d[c];
            count_q[c] <= count_d[c];
         end
         rr_q           <= rr_d;
         flushPending_q <= flushPending_d;
         flushDone_q    <= flushDone_d;
         ovfMask_q      <= ovfMask_d;
         oValid_q       <= oValid_d;
         oData_q        <= oData_d;
         oKeep_q        <= oKeep_d;
         oCol_q         <= oCol_d;
      end
   end

   // FIFO storage needs no reset since counts gate every read
   always_ff @(posedge clk) begin
      for (int c = 0; c < ARRAY_WIDTH; c++) begin
         if (pushOk[c]) begin
            mem_q[c][wrPtr_q[c]] <= aw_cb_data[c];
         end
      end
   end

   assign o_valid      = oValid_q;
   assign o_data       = oData_q;
   assign o_keep       = oKeep_q;
   assign o_col        = oCol_q;
   assign o_flush_done = flushDone_q;
   assign o_ovf_mask   = ovfMask_q;
   assign o_overflow   = |ovfMask_q;
   assign o_idle       = allEmpty && !oValid_q && !flushPending_q;

endmodule
